lsu_issue_ctrl: RTL and testbench
=================================

Name: lsu_issue_ctrl

Overview:
- Load/store issue sequencer between the head of the two-line FIFO and the single data-memory port.
- Takes the FIFO head entry, issues it to memory with a req/gnt handshake and pops the FIFO.
- For loads, waits for read data and presents a writeback beat with Rd.
- Strictly in order, at most one memory transaction outstanding; a sticky timeout flag guards against a hung memory port.

Parameters:
DataWidth, 92, FIFO entry width; field layout from lsu_pkg.
TimeoutCycles, 255, max cycles in REQ or WAIT before err_timeout is set; counter width is clog2(TimeoutCycles+1).

Ports:
clk  in  1  clock, rising edge.
rstN  in  1  asynchronous active-low reset.
headData  in  DataWidth  FIFO readData; all-zero means empty.
readEn  out  1  pop pulse to FIFO, combinational: high exactly in the grant cycle, or the skip cycle.
mem_req  out  1  memory request valid, registered.
mem_we  out  1  1 = store, registered.
mem_addr  out  32  byte address, registered.
mem_wdata  out  32  store data, registered.
mem_gnt  in  1  memory accepts request this cycle.
mem_rvalid  in  1  load data valid.
mem_rdata  in  32  load data.
wb_valid  out  1  writeback beat valid, registered.
wb_rd  out  6  destination; bit 5 = FP register file.
wb_data  out  32  load result.
wb_ready  in  1  writeback slot accepted this cycle.
busy  out  1  state != IDLE.
err_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (async, rstN=0): state=IDLE. mem_req, mem_we, wb_valid, err_timeout=0. mem_addr, mem_wdata, wb_rd, wb_data=0. Timeout counter=0.
- Entry decode (lsu_pkg):
  - rd=[91:86], addr=[85:54], wdata=[53:22], pc=[21:4].
  - mem_write=[3], is_load=[2], scan=[1].
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - If headData==0: stay.
  - Skip case: headData!=0, mem_write=0, scan=0 and rd==0 (a load killed by the FIFO's Rd scrub). Assert readEn this cycle and stay in IDLE; no memory access.
  - Otherwise: latch the entry into the holding register and drive mem_req/we/addr/wdata from it next cycle. Go to REQ. Head-valid to mem_req is 1 cycle.
- REQ:
  - Hold mem_req and all fields stable until mem_gnt.
  - In the mem_gnt cycle: readEn=1 (pop) and mem_req drops next cycle.
  - Store: go to IDLE.
  - Load or scan: go to WAIT.
- WAIT:
  - On mem_rvalid: capture mem_rdata into wb_data and rd into wb_rd; set wb_valid next cycle; go to WB.
  - mem_rvalid in the same cycle as mem_gnt is illegal; memory data arrives no earlier than gnt+1.
- WB:
  - Hold wb_valid, wb_rd, wb_data until wb_ready.
  - On wb_ready: wb_valid=0 next cycle, go to IDLE.
  - Scan with rd==0 (scrubbed): skip WB, go from WAIT directly to IDLE. Side effect done, data dropped.
  - Load with rd==0 cannot reach WAIT.
- Back-to-back:
  - Minimum 2 cycles per store (IDLE->REQ, gnt).
  - Loads take 3 + memory latency + wb stall cycles.
  - No new request while in WAIT or WB.
- Timeout:
  - Counter clears on every state entry and increments each cycle in REQ or WAIT.
  - Reaching TimeoutCycles sets err_timeout. The FSM keeps waiting; it does not abort.
- Holding register:
  - Popping in the gnt cycle is safe: outputs come from the latched copy, never from headData after IDLE.
  - A FIFO Rd scrub after latching has no effect on the latched entry.
- Reset mid-operation:
  - Immediate return to IDLE; outputs as reset.
  - The outstanding memory transaction is abandoned; memory is reset together with the core.
- Simultaneous wb_ready and new headData in WB: the transition to IDLE happens first. The new entry is examined in IDLE the next cycle.

Decomposition:
- lsu_pkg holds:
  - field offset localparams (RD_HI/LO, ADDR_HI/LO, WDATA_HI/LO, PC_HI/LO, MEMWRITE_BIT, ISLOAD_BIT, SCAN_BIT);
  - typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} lsu_state_t;
  - typedef struct packed lsu_entry_t matching the 92-bit layout.
- One sub-module: lsu_timeout_cnt (clear, enable, parameter TimeoutCycles, sticky flag out).
- FSM and holding register stay in lsu_issue_ctrl.

Test Plan:
- Store: head={rd=0, addr=0x100, wdata=0xDEADBEEF, mem_write=1}, mem_gnt 2 cycles after mem_req -> mem_req high 2 cycles, mem_we=1, addr=0x100. readEn pulses once, in the gnt cycle. Back in IDLE, busy=0, wb_valid never set.
- Load: head={rd=6'd5, addr=0x200, is_load=1}, gnt immediate, rvalid 3 cycles later with rdata=0x12345678, wb_ready=1 -> wb_valid for 1 cycle, wb_rd=5, wb_data=0x12345678.
- Writeback backpressure: same load with wb_ready low 4 cycles -> wb_valid/rd/data stable for 5 cycles. No new mem_req even though the next store is at the head.
- Skip: head={is_load=1, rd=0} -> readEn high in the same cycle, mem_req never asserted. Next entry is issued the following cycle.
- Scan scrubbed: scan=1, rd=0 -> mem_req issued, WAIT until rvalid, then IDLE with no wb_valid.
- Timeout/reset: TimeoutCycles=8, mem_gnt held low -> err_timeout=1 at cycle 8 of REQ, mem_req still high. Assert rstN=0 asynchronously -> all outputs 0 with no clock edge; err_timeout cleared.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and field layout for the load/store issue
//               sequencer: FIFO entry decode, FSM state encoding, helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   localparam int LSU_ENTRY_W  = 92;

   localparam int RD_HI        = 91;
   localparam int RD_LO        = 86;
   localparam int ADDR_HI      = 85;
   localparam int ADDR_LO      = 54;
   localparam int WDATA_HI     = 53;
   localparam int WDATA_LO     = 22;
   localparam int PC_HI        = 21;
   localparam int PC_LO        = 4;
   localparam int MEMWRITE_BIT = 3;
   localparam int ISLOAD_BIT   = 2;
   localparam int SCAN_BIT     = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      WB   = 2'd3
   } lsu_state_t;

   // Packed view of one FIFO entry, MSB first; bit 0 is reserved.
   typedef struct packed {
      logic [RD_HI-RD_LO:0]       rd;
      logic [ADDR_HI-ADDR_LO:0]   addr;
      logic [WDATA_HI-WDATA_LO:0] wdata;
      logic [PC_HI-PC_LO:0]       pc;
      logic                       mem_write;
      logic                       is_load;
      logic                       scan;
      logic                       rsvd;
   } lsu_entry_t;

   // Unpack a raw FIFO word into its named fields.
   function automatic lsu_entry_t lsu_decode(input logic [LSU_ENTRY_W-1:0] raw);
      lsu_entry_t e;
      e.rd        = raw[RD_HI:RD_LO];
      e.addr      = raw[ADDR_HI:ADDR_LO];
      e.wdata     = raw[WDATA_HI:WDATA_LO];
      e.pc        = raw[PC_HI:PC_LO];
      e.mem_write = raw[MEMWRITE_BIT];
      e.is_load   = raw[ISLOAD_BIT];
      e.scan      = raw[SCAN_BIT];
      e.rsvd      = raw[0];
      return e;
   endfunction

   // A load whose Rd was scrubbed by the FIFO: pop it without touching memory.
   function automatic logic lsu_is_skip(input lsu_entry_t e);
      return (e != '0) && !e.mem_write && !e.scan && (e.rd == '0);
   endfunction

   // A scan whose Rd was scrubbed: memory side effect only, result dropped.
   function automatic logic lsu_is_scrubbed_scan(input lsu_entry_t e);
      return e.scan && (e.rd == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : lsu_timeout_cnt
// Description : Saturating wait-cycle counter with a sticky timeout flag.
//               Flag rises on the cycle the count reaches TimeoutCycles and
//               stays high until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_timeout_cnt #(
   parameter int TimeoutCycles = 255
) (
   input  logic clk,
   input  logic rstN,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam int                c_CNT_W = $clog2(TimeoutCycles + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TimeoutCycles);

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_timeout;
   logic [c_CNT_W-1:0] w_cnt_inc;
   logic               w_hit;

   assign w_cnt_inc = r_cnt + c_CNT_W'(1);
   assign w_hit     = en && !clr && (r_cnt != c_LIMIT) && (w_cnt_inc == c_LIMIT);
   assign timeout   = r_timeout;

   // Count enabled cycles, saturate at the limit, clear on request.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != c_LIMIT)) begin
         r_cnt <= w_cnt_inc;
      end
   end

   // Sticky flag: set once the limit is reached, only reset clears it.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_timeout <= 1'b0;
      end else if (w_hit) begin
         r_timeout <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lsu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_issue_ctrl
// Description : In-order load/store issue sequencer. Latches the FIFO head,
//               issues it on the memory req/gnt port, pops the FIFO on grant
//               and returns load data as a writeback beat. One transaction
//               outstanding at most; a sticky timeout flags a hung port.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_issue_ctrl
   import lsu_pkg::*;
#(
   parameter int DataWidth     = 92,
   parameter int TimeoutCycles = 255
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic [DataWidth-1:0] headData,
   output logic                 readEn,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [31:0]          mem_rdata,
   output logic                 wb_valid,
   output logic [5:0]           wb_rd,
   output logic [31:0]          wb_data,
   input  logic                 wb_ready,
   output logic                 busy,
   output logic                 err_timeout
);

   lsu_state_t  r_state;
   lsu_entry_t  r_entry;
   logic        r_mem_req;
   logic        r_wb_valid;
   logic [5:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   lsu_entry_t  w_head;
   logic        w_head_valid;
   logic        w_skip;
   logic        w_tmo_clr;
   logic        w_tmo_en;
   logic        w_unused;

   assign w_head       = lsu_decode(headData);
   assign w_head_valid = (headData != '0);
   assign w_skip       = lsu_is_skip(w_head);

   // Pop on grant, or immediately for a scrubbed load sitting at the head.
   assign readEn = ((r_state == IDLE) && w_skip) || ((r_state == REQ) && mem_gnt);

   // Memory-side fields come straight from the holding register, so popping
   // the FIFO in the grant cycle cannot disturb them.
   assign mem_req     = r_mem_req;
   assign mem_we      = r_entry.mem_write;
   assign mem_addr    = r_entry.addr;
   assign mem_wdata   = r_entry.wdata;
   assign wb_valid    = r_wb_valid;
   assign wb_rd       = r_wb_rd;
   assign wb_data     = r_wb_data;
   assign busy        = (r_state != IDLE);

   // Counter runs only in REQ/WAIT and restarts whenever a state is entered.
   assign w_tmo_en  = (r_state == REQ) || (r_state == WAIT);
   assign w_tmo_clr = (r_state == IDLE) || (r_state == WB) ||
                      ((r_state == REQ)  && mem_gnt) ||
                      ((r_state == WAIT) && mem_rvalid);

   assign w_unused = ^{r_entry.pc, r_entry.is_load, r_entry.rsvd};

   lsu_timeout_cnt #(
      .TimeoutCycles (TimeoutCycles)
   ) u_timeout (
      .clk     (clk),
      .rstN    (rstN),
      .clr     (w_tmo_clr),
      .en      (w_tmo_en),
      .timeout (err_timeout)
   );

   // Issue FSM with holding register and registered memory/writeback outputs.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state    <= IDLE;
         r_entry    <= '0;
         r_mem_req  <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_head_valid && !w_skip) begin
                  r_entry   <= w_head;
                  r_mem_req <= 1'b1;
                  r_state   <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= r_entry.mem_write ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  if (lsu_is_scrubbed_scan(r_entry)) begin
                     r_state <= IDLE;
                  end else begin
                     r_wb_valid <= 1'b1;
                     r_wb_rd    <= r_entry.rd;
                     r_wb_data  <= mem_rdata;
                     r_state    <= WB;
                  end
               end
            end
            WB: begin
               if (wb_ready) begin
                  r_wb_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_issue_ctrl
// Description : Directed self-checking bench for lsu_issue_ctrl: store, load,
//               writeback backpressure, skip, scrubbed scan, timeout and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_issue_ctrl;

   logic        clk;
   logic        rstN;
   logic [91:0] headData;
   logic        readEn;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic        busy;
   logic        err_timeout;

   int n_cmp = 0;
   int n_err = 0;

   lsu_issue_ctrl #(
      .DataWidth     (92),
      .TimeoutCycles (8)
   ) dut (
      .clk         (clk),
      .rstN        (rstN),
      .headData    (headData),
      .readEn      (readEn),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_ready    (wb_ready),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a FIFO word: {rd, addr, wdata, pc, mem_write, is_load, scan, rsvd}.
   function automatic logic [91:0] mk(input logic [5:0] rd, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic mw,
                                      input logic ld, input logic sc);
      return {rd, addr, wdata, 18'h0, mw, ld, sc, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstN       = 1'b0;
      headData   = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      wb_ready   = 1'b0;

      // ---------------- reset state ----------------
      step();
      chk("rst_mem_req",  mem_req,     0);
      chk("rst_mem_we",   mem_we,      0);
      chk("rst_addr",     mem_addr,    0);
      chk("rst_wb_valid", wb_valid,    0);
      chk("rst_busy",     busy,        0);
      chk("rst_err",      err_timeout, 0);
      chk("rst_readEn",   readEn,      0);
      rstN = 1'b1;
      step();

      // ---------------- store, gnt in 2nd request cycle ----------------
      headData = mk(6'd0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
      #1 chk("st_idle_readEn", readEn, 0);
      step();
      chk("st_req1",      mem_req,   1);
      chk("st_we",        mem_we,    1);
      chk("st_addr",      mem_addr,  32'h100);
      chk("st_wdata",     mem_wdata, 32'hDEADBEEF);
      chk("st_busy",      busy,      1);
      chk("st_req1_rdEn", readEn,    0);
      step();
      chk("st_req2",      mem_req,   1);
      chk("st_addr2",     mem_addr,  32'h100);
      mem_gnt = 1'b1;
      #1 chk("st_gnt_readEn", readEn, 1);
      step();
      mem_gnt  = 1'b0;
      headData = '0;
      #1;
      chk("st_done_req",  mem_req,  0);
      chk("st_done_busy", busy,     0);
      chk("st_done_wbv",  wb_valid, 0);
      chk("st_done_rdEn", readEn,   0);

      // ---------------- load, gnt immediate, rvalid 3 cycles later ----------------
      headData = mk(6'd5, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      chk("ld_req",  mem_req,  1);
      chk("ld_we",   mem_we,   0);
      chk("ld_addr", mem_addr, 32'h200);
      mem_gnt = 1'b1;
      #1 chk("ld_gnt_readEn", readEn, 1);
      step();
      mem_gnt  = 1'b0;
      headData = '0;
      #1;
      chk("ld_wait_req",  mem_req, 0);
      chk("ld_wait_busy", busy,    1);
      step();
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      #1 chk("ld_pre_wbv", wb_valid, 0);
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      wb_ready   = 1'b1;
      #1;
      chk("ld_wbv",  wb_valid, 1);
      chk("ld_wbrd", wb_rd,    5);
      chk("ld_wbd",  wb_data,  32'h12345678);
      step();
      wb_ready = 1'b0;
      #1;
      chk("ld_wbv_drop", wb_valid, 0);
      chk("ld_idle",     busy,     0);

      // ---------------- load with writeback backpressure ----------------
      headData = mk(6'd5, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt  = 1'b0;
      headData = mk(6'd0, 32'h300, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < 5; i++) begin
         wb_ready = (i == 4);
         #1;
         chk("bp_wbv",   wb_valid, 1);
         chk("bp_wbrd",  wb_rd,    5);
         chk("bp_wbd",   wb_data,  32'h12345678);
         chk("bp_noreq", mem_req,  0);
         step();
      end
      wb_ready = 1'b0;
      #1;
      chk("bp_wbv_drop",   wb_valid, 0);
      chk("bp_idle_noreq", mem_req,  0);
      step();
      chk("bp_next_req",  mem_req,  1);
      chk("bp_next_addr", mem_addr, 32'h300);
      chk("bp_next_we",   mem_we,   1);
      mem_gnt = 1'b1;
      step();
      mem_gnt  = 1'b0;
      headData = '0;
      #1 chk("bp_done_busy", busy, 0);

      // ---------------- skip scrubbed load ----------------
      headData = mk(6'd0, 32'h380, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("skip_readEn", readEn,  1);
      chk("skip_noreq",  mem_req, 0);
      step();
      headData = mk(6'd0, 32'h400, 32'h55AA55AA, 1'b1, 1'b0, 1'b0);
      #1;
      chk("skip_noreq2",   mem_req, 0);
      chk("skip_busy",     busy,    0);
      chk("skip_readEn2",  readEn,  0);
      step();
      chk("skip_next_req",  mem_req,  1);
      chk("skip_next_addr", mem_addr, 32'h400);
      mem_gnt = 1'b1;
      step();
      mem_gnt  = 1'b0;
      headData = '0;
      #1 chk("skip_done_busy", busy, 0);

      // ---------------- scrubbed scan ----------------
      headData = mk(6'd0, 32'h500, 32'h0, 1'b0, 1'b0, 1'b1);
      #1 chk("scan_readEn_idle", readEn, 0);
      step();
      chk("scan_req",  mem_req,  1);
      chk("scan_addr", mem_addr, 32'h500);
      chk("scan_we",   mem_we,   0);
      mem_gnt = 1'b1;
      step();
      mem_gnt  = 1'b0;
      headData = '0;
      #1 chk("scan_wait_busy", busy, 1);
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA5A5A5A5;
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("scan_idle", busy,     0);
      chk("scan_nowb", wb_valid, 0);
      step();
      chk("scan_nowb2", wb_valid, 0);

      // ---------------- timeout, then async reset ----------------
      headData = mk(6'd0, 32'h600, 32'h11112222, 1'b1, 1'b0, 1'b0);
      step();
      chk("tmo_req", mem_req, 1);
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 7) chk("tmo_err_early", err_timeout, 0);
      end
      chk("tmo_err",     err_timeout, 1);
      chk("tmo_req_hld", mem_req,     1);
      chk("tmo_busy",    busy,        1);
      #2 rstN = 1'b0;
      #1;
      chk("arst_req",   mem_req,     0);
      chk("arst_we",    mem_we,      0);
      chk("arst_addr",  mem_addr,    0);
      chk("arst_wdata", mem_wdata,   0);
      chk("arst_wbv",   wb_valid,    0);
      chk("arst_wbrd",  wb_rd,       0);
      chk("arst_wbd",   wb_data,     0);
      chk("arst_busy",  busy,        0);
      chk("arst_err",   err_timeout, 0);
      headData = '0;
      step();
      rstN = 1'b1;
      step();
      chk("post_rst_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
